// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types and constants for the 8:1 mux scan controller.
// Imported by the interface, the settle timer and the top.
package mux_scan_ctrl_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    HOLD
  } state_t;

  // The timer reads zero on the last settle cycle, so it is loaded with n-1.
  function automatic logic [CNT_W-1:0] settle_load(
    input int unsigned n
  );
    if (n == 0) begin
      return '0;
    end
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Scan controller bus: start/ready handshake, mux select and sample,
// and the assembled result word.
interface mux_scan_ctrl_if;
  import mux_scan_ctrl_pkg::*;

  logic              start;
  logic [SEL_W-1:0]  sel;
  logic              mux_out;
  logic [NUM_CH-1:0] word;
  logic              valid;
  logic              ready;
  logic              busy;

  modport master (
    input  start,
    input  mux_out,
    input  ready,
    output sel,
    output word,
    output valid,
    output busy
  );

  modport slave (
    output start,
    output mux_out,
    output ready,
    input  sel,
    input  word,
    input  valid,
    input  busy
  );

endinterface

// File: rtl/mux_scan_ctrl_settle_timer.sv
// Loadable 4-bit down-counter with a zero flag.
// Load has priority over decrement; it never wraps below zero.
module settle_timer
  import mux_scan_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans an external 8:1 mux channel by channel, settling after each
// select change, and presents the assembled word with valid/ready.
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_scan_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] LOAD_VAL =
    settle_load(SETTLE_CYCLES);
  localparam bit NO_SETTLE = (SETTLE_CYCLES == 0);
  localparam logic [SEL_W-1:0] LAST_CH =
    SEL_W'(NUM_CH - 1);

  state_t            r_state;
  logic [SEL_W-1:0]  r_sel;
  logic [NUM_CH-1:0] r_word;
  logic              r_valid;
  logic              r_busy;

  logic w_zero;
  logic w_load;
  logic w_dec;
  logic w_start;
  logic w_last;
  logic w_hs;

  assign w_last  = (r_sel == LAST_CH);
  assign w_hs    = (r_state == HOLD) && bus.ready;
  assign w_start = bus.start &&
                   ((r_state == IDLE) || w_hs);

  // Reload the timer on every entry into SETTLE.
  always_comb begin
    w_load = 1'b0;
    w_dec  = 1'b0;
    unique case (1'b1)
      w_start: begin
        w_load = 1'b1;
      end
      (r_state == SAMPLE) && !w_last: begin
        w_load = 1'b1;
      end
      (r_state == SETTLE): begin
        w_dec = !w_zero;
      end
      default: begin
        w_load = 1'b0;
      end
    endcase
  end

  settle_timer u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_val  (LOAD_VAL),
    .i_dec  (w_dec),
    .o_zero (w_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            r_sel   <= '0;
            r_word  <= '0;
            r_busy  <= 1'b1;
            r_state <= NO_SETTLE ? SAMPLE : SETTLE;
          end
        end
        SETTLE: begin
          if (w_zero) begin
            r_state <= SAMPLE;
          end
        end
        SAMPLE: begin
          r_word[r_sel] <= bus.mux_out;
          if (w_last) begin
            r_valid <= 1'b1;
            r_state <= HOLD;
          end else begin
            r_sel   <= r_sel + SEL_W'(1);
            r_state <= NO_SETTLE ? SAMPLE : SETTLE;
          end
        end
        HOLD: begin
          if (w_hs) begin
            r_valid <= 1'b0;
            if (w_start) begin
              r_sel   <= '0;
              r_word  <= '0;
              r_state <= NO_SETTLE ? SAMPLE : SETTLE;
            end else begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
      endcase
    end
  end

  assign bus.sel   = r_sel;
  assign bus.word  = r_word;
  assign bus.valid = r_valid;
  assign bus.busy  = r_busy;

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 1, giving the number of wait cycles after each select change before sampling; legal range 0..15.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, a request to begin one 8-channel scan.
REQ-005 The block SHALL have port sel, output, 3, driving mux select S2:S0, with sel[0] to S0.
REQ-006 The block SHALL have port mux_out, input, 1, the 8:1 mux output being sampled.
REQ-007 The block SHALL have port word, output, 8, the assembled scan result, with bit i taken from channel Di.
REQ-008 The block SHALL have port valid, output, 1, meaning word is complete and held.
REQ-009 The block SHALL have port ready, input, 1, the consumer's acceptance of word.
REQ-010 The block SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-011 The FSM SHALL have states IDLE, SETTLE, SAMPLE and HOLD.
REQ-012 In IDLE, start=1 SHALL load sel=0, clear word to 0x00 and enter SETTLE, or enter SAMPLE directly when SETTLE_CYCLES=0.
REQ-013 SETTLE SHALL last exactly SETTLE_CYCLES cycles, with sel held constant, then transition to SAMPLE.
REQ-014 SAMPLE SHALL last one cycle and SHALL write mux_out into word[sel] at its ending edge.
REQ-015 Leaving SAMPLE with sel<7, the block SHALL increment sel and return to SETTLE, or to SAMPLE when SETTLE_CYCLES=0.
REQ-016 Leaving SAMPLE with sel=7, the block SHALL enter HOLD, set valid=1 and keep sel=7.
REQ-017 Latency from the start-accept edge to valid=1 SHALL be exactly 8*(SETTLE_CYCLES+1) cycles.
REQ-018 In HOLD, word and valid SHALL remain stable until a cycle with valid=1 and ready=1.
REQ-019 On that handshake cycle, valid SHALL drop and the FSM SHALL go to IDLE, or restart per REQ-012 if start=1 in the same cycle.
REQ-020 ready SHALL be ignored outside HOLD.
REQ-021 start SHALL be ignored in SETTLE, SAMPLE and HOLD, except as allowed by REQ-019; start is never queued.
REQ-022 sel SHALL change only on SAMPLE exit or on scan start, so it never changes mid-settle.

Reset
REQ-023 While rst_n=0, the block SHALL immediately force IDLE, sel=0, word=0x00, valid=0, busy=0 and settle counter=0.
REQ-024 Reset asserted mid-scan or in HOLD SHALL abandon the scan, with no partial word or valid emitted afterwards.
REQ-025 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-026 A shared package SHALL hold the state enum (IDLE, SETTLE, SAMPLE, HOLD), the constants NUM_CH=8, SEL_W=3 and CNT_W=4.
REQ-027 A single sub-module, settle_timer, SHALL implement the loadable 4-bit down-counter with a zero flag.
REQ-028 The top SHALL instantiate settle_timer once, and it SHALL contain no mux logic itself.

Verification
REQ-029 SETTLE_CYCLES=1, D7..D0=10110010 on a behavioural 8:1 mux, start pulsed 1 cycle -> valid rises 16 cycles later, word=0xB2, sel sequence 0..7 each held 2 cycles.
REQ-030 SETTLE_CYCLES=0, all D=1 -> valid after 8 cycles, word=0xFF.
REQ-031 In HOLD with ready=0 for 5 cycles, change D inputs -> word stays unchanged and valid stays 1; ready=1 -> valid=0 next cycle, busy=0.
REQ-032 ready=1 and start=1 together in HOLD -> valid drops, new scan starts with sel=0, and the next word matches the new D pattern 0x5A.
REQ-033 rst_n=0 asserted for 1 cycle at channel 4 of a scan -> outputs go to reset values immediately; a later start yields a full correct word 0x3C.
REQ-034 start held high throughout a scan -> exactly one scan runs and no extra valid pulse appears before the handshake.
